// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: single-outstanding instruction fetch front end with a one-entry instruction buffer.
// Optional feature macro FETCH_MISALIGN_CHECK_EN: misaligned redirect/flush targets trap into a sticky FAULT state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    output logic        misalign_fault
);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_START,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
`ifdef FETCH_MISALIGN_CHECK_EN
        , S_FAULT
`endif
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] instr_pc_reg, instr_pc_next;
    logic [31:0] redirect_addr, flush_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_reg, fault_next;
    logic pend_reg, pend_next;
    logic redirect_bad, flush_bad;

    // Targets are taken verbatim; a nonzero low pair is trapped instead of masked.
    assign redirect_addr = redirect_target;
    assign flush_addr    = flush_pc;
    assign redirect_bad  = |redirect_target[1:0];
    assign flush_bad     = |flush_pc[1:0];
`else
    assign redirect_addr = redirect_target & ~32'h3;
    assign flush_addr    = flush_pc & ~32'h3;
`endif

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_next = fault_reg;
        pend_next  = pend_reg;
        // Tracks an in-flight response so leaving FAULT can still drain it.
        if (imem_rsp_valid)
            pend_next = 1'b0;
        if (state_reg == S_REQ && imem_req_ready)
            pend_next = 1'b1;
`endif
        case (state_reg)
            S_START: state_next = S_REQ;
            S_REQ: begin
                if (imem_req_ready)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_next    = imem_rsp_data;
                    instr_pc_next = pc_reg;
                    state_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_next = S_REQ;
                    pc_next    = redirect_valid ? redirect_addr : pc_reg + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (redirect_valid && redirect_bad) begin
                        state_next    = S_FAULT;
                        fault_next    = 1'b1;
                        instr_pc_next = redirect_target;
                    end
`endif
                end
            end
            S_DROP: begin
                if (imem_rsp_valid)
                    state_next = S_REQ;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_START;
        endcase

        // Flush overrides whatever the state logic decided above, including a concurrent capture.
        if (flush_valid) begin
            pc_next       = flush_addr;
            instr_next    = instr_reg;
            instr_pc_next = instr_pc_reg;
            case (state_reg)
                S_REQ:  state_next = imem_req_ready ? S_DROP : S_REQ;
                S_WAIT: state_next = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD: state_next = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                S_FAULT: state_next = (pend_reg && !imem_rsp_valid) ? S_DROP : S_REQ;
`endif
                default: ;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (flush_bad) begin
                state_next    = S_FAULT;
                fault_next    = 1'b1;
                instr_pc_next = flush_pc;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_START;
            pc_reg       <= RESET_PC;
            instr_reg    <= NOP_INSTR;
            instr_pc_reg <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_reg    <= 1'b0;
            pend_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_reg    <= fault_next;
            pend_reg     <= pend_next;
`endif
        end
    end

    assign imem_req_valid = (state_reg == S_REQ);
    assign imem_req_addr  = pc_reg;
    assign instr_valid    = (state_reg == S_HOLD);
    assign instr          = instr_reg;
    assign instr_pc       = instr_pc_reg;
    assign opcode         = instr_reg[6:0];
    assign funct3         = instr_reg[14:12];
    assign funct7b5       = instr_reg[30];
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_fault = fault_reg;
`else
    assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed scenarios plus randomized traffic, checked against a transaction-level
// model of the fetch stream (expected next fetch address, outstanding responses, buffered instruction).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        redirect_valid, flush_valid;
    logic [31:0] redirect_target, flush_pc;
    logic        misalign_fault;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .misalign_fault(misalign_fault)
    );

    typedef struct {
        logic [31:0] addr;    // address the DUT actually sent (memory side)
        logic [31:0] exp_pc;  // address the model says it should carry
        int          due;
        bit          killed;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          started = 0;
    bit          buf_v = 0;
    bit          faulted = 0;
    bit          fault_seen = 0;
    logic [31:0] buf_pc = 32'h0;
    logic [31:0] exp_next = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a;
`else
        return a & ~32'h3;
`endif
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model, move to next negedge.
    task automatic step(input bit rq_rdy, input bit in_rdy, input bit rd_v, input logic [31:0] rd_t,
                        input bit fl_v, input logic [31:0] fl_t);
        bit          exp_req, acc, cons, rsp;
        logic [31:0] w;
        rsp_t        e;
        exp_req = started && !buf_v && !faulted && (rsp_q.size() == 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req)
            check("req_addr", imem_req_addr, exp_next);
        check("instr_valid", 32'(instr_valid), 32'(buf_v));
        if (buf_v) begin
            w = mem_word(buf_pc);
            check("instr", instr, w);
            check("instr_pc", instr_pc, buf_pc);
            check("decode", {21'b0, opcode, funct3, funct7b5}, {21'b0, w[6:0], w[14:12], w[30]});
        end
        check("misalign_fault", 32'(misalign_fault), 32'(fault_seen));

        rsp = (rsp_q.size() != 0) && (rsp_q[0].due <= cyc);
        imem_req_ready  = rq_rdy;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = rsp ? mem_word(rsp_q[0].addr) : $urandom;
        instr_ready     = in_rdy;
        redirect_valid  = rd_v;
        redirect_target = rd_t;
        flush_valid     = fl_v;
        flush_pc        = fl_t;

        acc  = exp_req && rq_rdy;
        cons = buf_v && in_rdy;
        if (rsp) begin
            e = rsp_q.pop_front();
            if (!e.killed) begin
                buf_v  = 1'b1;
                buf_pc = e.exp_pc;
            end
        end
        if (cons) begin
            buf_v = 1'b0;
            $display("consume pc=%h instr=%h redirect=%0d flush=%0d", buf_pc, mem_word(buf_pc), rd_v, fl_v);
            if (!fl_v) begin
                if (rd_v && is_bad(rd_t)) begin
                    faulted    = 1'b1;
                    fault_seen = 1'b1;
                end else begin
                    exp_next = rd_v ? align(rd_t) : buf_pc + 32'd4;
                end
            end
        end
        if (acc) begin
            e.addr   = imem_req_addr;
            e.exp_pc = exp_next;
            e.due    = cyc + int'($urandom_range(lat_max, lat_min));
            e.killed = 1'b0;
            rsp_q.push_back(e);
        end
        if (fl_v) begin
            foreach (rsp_q[i]) rsp_q[i].killed = 1'b1;
            buf_v = 1'b0;
            if (is_bad(fl_t)) begin
                faulted    = 1'b1;
                fault_seen = 1'b1;
            end else begin
                faulted  = 1'b0;
                exp_next = align(fl_t);
            end
        end
        started = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_instr(input int max);
        int k = 0;
        while (!instr_valid && k < max) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            k++;
        end
        check("wait_instr_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(input int max);
        int k = 0;
        while (!imem_req_valid && k < max) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            k++;
        end
        check("wait_req_valid", 32'(imem_req_valid), 32'd1);
    endtask

    initial begin
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; instr_ready = 0;
        redirect_valid = 0; redirect_target = 0; flush_valid = 0; flush_pc = 0;
        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h13);
        check("rst_funct3", 32'(funct3), 32'd0);
        check("rst_funct7b5", 32'(funct7b5), 32'd0);
        check("rst_fault", 32'(misalign_fault), 32'd0);
        rst_n = 1'b1;

        // Back-to-back fetch at best-case cadence.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Core stalls for 5 cycles while holding an instruction.
        wait_instr(20);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Taken branch to 0x100.
        wait_instr(20);
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        check("redirect_addr", imem_req_addr, 32'h100);

        // Flush while waiting on a slow response.
        lat_min = 3; lat_max = 3;
        wait_req(20);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        wait_req(20);
        check("flush_addr", imem_req_addr, 32'h40);

        // Retarget an unaccepted request to the top of memory, then wrap.
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        wait_instr(20);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_addr", imem_req_addr, 32'h0);

        // Misaligned redirect target.
        wait_instr(20);
        step(1'b1, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("fault_flag", 32'(misalign_fault), 32'd1);
        check("fault_pc", instr_pc, 32'h102);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        check("resume_valid", 32'(imem_req_valid), 32'd1);
        check("resume_addr", imem_req_addr, 32'h200);
`else
        check("misalign_addr", imem_req_addr, 32'h100);
`endif

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt, ft;
            rt = $urandom;
            ft = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            rt = rt & ~32'h3;
            ft = ft & ~32'h3;
`endif
            step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 10) < 3, rt,
                 ($urandom % 32) == 0, ft);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
